i2c_datapath: RTL and testbench

Bit-level datapath driven by the I2C controller FSM: generates the I2C bit clock `ClockI2C` (fed back to the controller), loads and serialises the transmit byte onto SDA, drives start/stop/ack levels, and captures the slave ACK. It sits directly downstream of the controller, consuming its `BaudEnable`, `ReadorWrite`, `Select`, `ShiftorHold`, `StartStopAck` and `WriteLoad` outputs, and connects to the open-drain SDA/SCL pads.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_baud_divider.sv | 59 +++++
 rtl/i2c_datapath.sv | 99 +++++++++
 tb/tb_i2c_datapath.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C controller/datapath pair: default sizing, controller state
// encodings and the saturating bit-counter helper.
package i2c_pkg;

  localparam int unsigned I2cDataWidth = 8;
  localparam int unsigned I2cDivide    = 250;

  localparam int unsigned BitCntWidth = 4;
  localparam logic [BitCntWidth-1:0] BitCntMax = '1;

  typedef enum logic [2:0] {
    StInitial,
    StStart,
    StLoad,
    StWrite,
    StAcknowledge,
    StTransit,
    StStop
  } i2c_state_e;

  function automatic logic [BitCntWidth-1:0] bit_cnt_inc(input logic [BitCntWidth-1:0] cnt);
    return (cnt == BitCntMax) ? cnt : cnt + BitCntWidth'(1);
  endfunction

endpackage

// File: rtl/i2c_baud_divider.sv
// SCL generator: divides the system clock into ClockI2C and flags each divider-driven SCL edge
// with a one-cycle strobe in the cycle following the edge.
module i2c_baud_divider #(
  parameter int unsigned DIVIDE = 250
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic baud_en_i,
  output logic scl_o,
  output logic fall_strobe_o,
  output logic rise_strobe_o
);

  localparam int unsigned CntW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIVIDE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            scl_q, scl_d;
  logic            fall_q, fall_d;
  logic            rise_q, rise_d;

  always_comb begin
    cnt_d  = cnt_q;
    scl_d  = scl_q;
    fall_d = 1'b0;
    rise_d = 1'b0;
    if (!baud_en_i) begin
      // Forced idle-high level is not a divider edge, so it never strobes.
      cnt_d = '0;
      scl_d = 1'b1;
    end else if (cnt_q == CntMax) begin
      cnt_d  = '0;
      scl_d  = ~scl_q;
      fall_d = scl_q;
      rise_d = ~scl_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      scl_q  <= 1'b1;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      scl_q  <= scl_d;
      fall_q <= fall_d;
      rise_q <= rise_d;
    end
  end

  assign scl_o         = scl_q;
  assign fall_strobe_o = fall_q;
  assign rise_strobe_o = rise_q;

endmodule

// File: rtl/i2c_datapath.sv
// I2C bit-level datapath: SCL generation, transmit shift register, registered SDA drive mux and
// slave ACK capture, all steered by the controller FSM's control outputs.
module i2c_datapath
  import i2c_pkg::*;
#(
  parameter int unsigned DIVIDE     = I2cDivide,
  parameter int unsigned DATA_WIDTH = I2cDataWidth
) (
  input  logic                   clock,
  input  logic                   Reset,
  input  logic [DATA_WIDTH-1:0]  DataIn,
  input  logic                   BaudEnable,
  input  logic                   ReadorWrite,
  input  logic                   Select,
  input  logic                   ShiftorHold,
  input  logic                   StartStopAck,
  input  logic                   WriteLoad,
  input  logic                   SDAIn,
  output logic                   ClockI2C,
  output logic                   SDAOut,
  output logic                   SDAEnable,
  output logic                   AckBit,
  output logic                   AckValid,
  output logic [BitCntWidth-1:0] BitsSent
);

  logic fall_strobe;
  logic rise_strobe;

  i2c_baud_divider #(
    .DIVIDE(DIVIDE)
  ) u_baud (
    .clk_i        (clock),
    .rst_i        (Reset),
    .baud_en_i    (BaudEnable),
    .scl_o        (ClockI2C),
    .fall_strobe_o(fall_strobe),
    .rise_strobe_o(rise_strobe)
  );

  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [BitCntWidth-1:0] bits_q, bits_d;
  logic                   sda_out_q, sda_out_d;
  logic                   sda_en_q, sda_en_d;
  logic                   ack_bit_q, ack_bit_d;
  logic                   ack_valid_q, ack_valid_d;

  // Shift register: a load always wins over a coincident falling-edge shift.
  always_comb begin
    shift_d = shift_q;
    bits_d  = bits_q;
    if (WriteLoad) begin
      shift_d = DataIn;
      bits_d  = '0;
    end else if (ShiftorHold && fall_strobe) begin
      shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
      bits_d  = bit_cnt_inc(bits_q);
    end
  end

  always_comb begin
    sda_out_d = 1'b1;
    sda_en_d  = 1'b0;
    if (!ReadorWrite) begin
      sda_en_d  = 1'b1;
      sda_out_d = Select ? shift_q[DATA_WIDTH-1] : StartStopAck;
    end
  end

  always_comb begin
    ack_valid_d = rise_strobe && ReadorWrite;
    ack_bit_d   = ack_valid_d ? SDAIn : ack_bit_q;
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      shift_q     <= '0;
      bits_q      <= '0;
      sda_out_q   <= 1'b1;
      sda_en_q    <= 1'b0;
      ack_bit_q   <= 1'b1;
      ack_valid_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bits_q      <= bits_d;
      sda_out_q   <= sda_out_d;
      sda_en_q    <= sda_en_d;
      ack_bit_q   <= ack_bit_d;
      ack_valid_q <= ack_valid_d;
    end
  end

  assign SDAOut    = sda_out_q;
  assign SDAEnable = sda_en_q;
  assign AckBit    = ack_bit_q;
  assign AckValid  = ack_valid_q;
  assign BitsSent  = bits_q;

endmodule

// File: tb/tb_i2c_datapath.sv
// Directed bench for i2c_datapath with DIVIDE=4: divider timing, serialisation, ACK capture,
// load/shift collision, start/stop levels and asynchronous reset.
module tb_i2c_datapath;

  localparam int unsigned Div = 4;

  logic       clock = 1'b0;
  logic       Reset;
  logic [7:0] DataIn;
  logic       BaudEnable, ReadorWrite, Select, ShiftorHold, StartStopAck, WriteLoad, SDAIn;
  logic       ClockI2C, SDAOut, SDAEnable, AckBit, AckValid;
  logic [3:0] BitsSent;

  int n_checks = 0;
  int n_errors = 0;

  i2c_datapath #(
    .DIVIDE    (Div),
    .DATA_WIDTH(8)
  ) dut (
    .clock       (clock),
    .Reset       (Reset),
    .DataIn      (DataIn),
    .BaudEnable  (BaudEnable),
    .ReadorWrite (ReadorWrite),
    .Select      (Select),
    .ShiftorHold (ShiftorHold),
    .StartStopAck(StartStopAck),
    .WriteLoad   (WriteLoad),
    .SDAIn       (SDAIn),
    .ClockI2C    (ClockI2C),
    .SDAOut      (SDAOut),
    .SDAEnable   (SDAEnable),
    .AckBit      (AckBit),
    .AckValid    (AckValid),
    .BitsSent    (BitsSent)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Divider must be idle (counter 0, SCL high) on entry. Load lands on the first fall strobe.
  task automatic send_byte(input logic [7:0] b, input string tag);
    Select      = 1'b1;
    ShiftorHold = 1'b1;
    ReadorWrite = 1'b0;
    BaudEnable  = 1'b1;
    tick(Div);
    chk({tag, "_scl_first_fall"}, ClockI2C, 1'b0);
    WriteLoad = 1'b1;
    DataIn    = b;
    tick(1);
    WriteLoad = 1'b0;
    chk({tag, "_bits_after_load"}, BitsSent, 4'd0);
    tick(Div - 1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_bit%0d", tag, k), SDAOut, b[7-k]);
      chk($sformatf("%s_scl_rise%0d", tag, k), ClockI2C, 1'b1);
      if (k < 7) tick(2 * Div);
    end
    tick(Div + 1);
    chk({tag, "_bits_sent8"}, BitsSent, 4'd8);
    tick(1);
    chk({tag, "_sda_drained"}, SDAOut, 1'b0);
  endtask

  initial begin
    Reset        = 1'b1;
    DataIn       = 8'h00;
    BaudEnable   = 1'b0;
    ReadorWrite  = 1'b0;
    Select       = 1'b0;
    ShiftorHold  = 1'b0;
    StartStopAck = 1'b0;
    WriteLoad    = 1'b0;
    SDAIn        = 1'b1;
    #3;
    chk("rst_scl", ClockI2C, 1'b1);
    chk("rst_sda_out", SDAOut, 1'b1);
    chk("rst_sda_en", SDAEnable, 1'b0);
    chk("rst_ack_bit", AckBit, 1'b1);
    chk("rst_ack_valid", AckValid, 1'b0);
    chk("rst_bits", BitsSent, 4'd0);
    #19 Reset = 1'b0;
    tick(1);

    // Divider timing; ShiftorHold=1 makes fall strobes visible on BitsSent.
    BaudEnable  = 1'b1;
    ShiftorHold = 1'b1;
    tick(3);
    chk("div_scl_t3", ClockI2C, 1'b1);
    tick(1);
    chk("div_scl_t4", ClockI2C, 1'b0);
    tick(1);
    chk("div_fall_shift1", BitsSent, 4'd1);
    tick(3);
    chk("div_scl_t8", ClockI2C, 1'b1);
    tick(4);
    chk("div_scl_t12", ClockI2C, 1'b0);
    tick(1);
    chk("div_fall_shift2", BitsSent, 4'd2);
    tick(1);
    BaudEnable  = 1'b0;
    ReadorWrite = 1'b1;
    tick(1);
    chk("div_forced_high", ClockI2C, 1'b1);
    chk("div_rw_release", SDAEnable, 1'b0);
    tick(1);
    chk("div_no_rise_strobe", AckValid, 1'b0);
    chk("div_ack_hold", AckBit, 1'b1);
    chk("div_no_shift_idle", BitsSent, 4'd2);
    ReadorWrite = 1'b0;

    // Load coincident with a fall strobe.
    Select     = 1'b1;
    BaudEnable = 1'b1;
    tick(Div);
    chk("col_scl_low", ClockI2C, 1'b0);
    WriteLoad = 1'b1;
    DataIn    = 8'h3C;
    tick(1);
    chk("col_shift_reg", dut.shift_q, 8'h3C);
    chk("col_bits", BitsSent, 4'd0);
    WriteLoad  = 1'b0;
    BaudEnable = 1'b0;
    tick(1);

    // Serialise 0xA5, then keep clocking to saturate BitsSent.
    send_byte(8'hA5, "a5");
    tick(16 * Div);
    chk("bits_saturate", BitsSent, 4'd15);
    BaudEnable = 1'b0;
    tick(1);

    // ACK capture with ReadorWrite and Select both high.
    ShiftorHold = 1'b0;
    ReadorWrite = 1'b1;
    Select      = 1'b1;
    SDAIn       = 1'b0;
    BaudEnable  = 1'b1;
    tick(1);
    chk("ack_sda_released", SDAEnable, 1'b0);
    chk("ack_sda_out_hi", SDAOut, 1'b1);
    tick(2 * Div - 1);
    chk("ack_valid_before", AckValid, 1'b0);
    tick(1);
    chk("ack0_bit", AckBit, 1'b0);
    chk("ack0_valid", AckValid, 1'b1);
    tick(1);
    chk("ack0_valid_pulse", AckValid, 1'b0);
    SDAIn = 1'b1;
    tick(2 * Div - 1);
    chk("nack_bit", AckBit, 1'b1);
    chk("nack_valid", AckValid, 1'b1);
    tick(1);
    chk("nack_valid_pulse", AckValid, 1'b0);
    BaudEnable  = 1'b0;
    ReadorWrite = 1'b0;
    tick(1);

    // Start/stop levels through the StartStopAck path.
    Select       = 1'b0;
    StartStopAck = 1'b0;
    tick(1);
    chk("ss_low", SDAOut, 1'b0);
    chk("ss_en", SDAEnable, 1'b1);
    StartStopAck = 1'b1;
    #1;
    chk("ss_not_yet", SDAOut, 1'b0);
    tick(1);
    chk("ss_high", SDAOut, 1'b1);
    chk("ss_en2", SDAEnable, 1'b1);

    // Asynchronous reset after three bits of 0xA5.
    Select      = 1'b1;
    ShiftorHold = 1'b1;
    BaudEnable  = 1'b1;
    tick(Div);
    WriteLoad = 1'b1;
    DataIn    = 8'hA5;
    tick(1);
    WriteLoad = 1'b0;
    tick(24);
    chk("mid_bits3", BitsSent, 4'd3);
    chk("mid_scl_low", ClockI2C, 1'b0);
    #3 Reset = 1'b1;
    #1;
    chk("arst_scl", ClockI2C, 1'b1);
    chk("arst_sda_en", SDAEnable, 1'b0);
    chk("arst_sda_out", SDAOut, 1'b1);
    chk("arst_bits", BitsSent, 4'd0);
    chk("arst_ack_bit", AckBit, 1'b1);
    chk("arst_ack_valid", AckValid, 1'b0);
    chk("arst_shift", dut.shift_q, 8'h00);
    BaudEnable = 1'b0;
    @(posedge clock);
    #2 Reset = 1'b0;
    tick(1);
    send_byte(8'hFF, "ff");
    BaudEnable = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
